sample_frame_buffer: RTL and testbench

SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

---
 rtl/sample_frame_buffer_pkg.sv | 14 +
 rtl/sample_frame_buffer_bank.sv | 28 ++
 rtl/sample_frame_buffer.sv | 144 ++++++++++++++
 tb/tb_sample_frame_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_frame_buffer_pkg.sv
// Shared definitions for the double-buffered sensor frame capture block.
// Holds the default frame length, FSM encodings and the blank read value.
package sample_frame_buffer_pkg;

    localparam int         DATA_LENGTH_DEFAULT = 115;
    localparam logic [7:0] OOR_DATA            = 8'h00;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        FILL       = 2'd1,
        SWAP       = 2'd2
    } state_t;

endpackage

// File: rtl/sample_frame_buffer_bank.sv
// frame_bank: DEPTH x 8 byte store, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write side), raddr -> rdata (combinational).
module frame_bank
    import sample_frame_buffer_pkg::*;
#(
    parameter int DEPTH = DATA_LENGTH_DEFAULT,
    parameter int IW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Index space is a power of two; guard the unused tail.
    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : OOR_DATA;

endmodule

// File: rtl/sample_frame_buffer.sv
// Double-buffered frame capture: fills one bank while the other is read.
// Ports: clk, rst, sample/sample_valid/frame_start/drop (capture side),
//        addr -> data (read side), frame_ready, overrun, frame_count.
module sample_frame_buffer
    import sample_frame_buffer_pkg::*;
#(
    parameter int DATA_LENGTH = DATA_LENGTH_DEFAULT,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            sample,
    input  logic                  sample_valid,
    input  logic                  frame_start,
    input  logic                  drop,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            data,
    output logic                  frame_ready,
    output logic                  overrun,
    output logic [7:0]            frame_count
);

    localparam int         IW   = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [7:0] LAST = 8'(DATA_LENGTH - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wr_ptr;
    logic [7:0] wr_ptr_nxt;
    logic [7:0] wr_idx;
    logic       we;
    logic       set_ovr;
    logic       do_swap;
    logic       bank_sel;
    logic       drop_q;
    logic       drop_req;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       in_range;

    // Each level change on drop is one request.
    assign drop_req = drop ^ drop_q;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_idx     = 8'd0;
        we         = 1'b0;
        set_ovr    = 1'b0;
        do_swap    = 1'b0;
        unique case (state)
            WAIT_START, FILL: begin
                if (drop_req) begin
                    state_nxt  = WAIT_START;
                    wr_ptr_nxt = 8'd0;
                end else if (frame_start) begin
                    // Restart; only counts as overrun mid-frame.
                    set_ovr    = (state == FILL);
                    state_nxt  = FILL;
                    wr_ptr_nxt = 8'd0;
                    if (sample_valid) begin
                        we = 1'b1;
                        if (LAST == 8'd0) begin
                            state_nxt = SWAP;
                        end else begin
                            wr_ptr_nxt = 8'd1;
                        end
                    end
                end else if (state == FILL && sample_valid) begin
                    we     = 1'b1;
                    wr_idx = wr_ptr;
                    if (wr_ptr == LAST) begin
                        state_nxt  = SWAP;
                        wr_ptr_nxt = 8'd0;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 8'd1;
                    end
                end
            end
            SWAP: begin
                // A drop here lands in WAIT_START anyway, after the swap.
                do_swap    = 1'b1;
                state_nxt  = WAIT_START;
                wr_ptr_nxt = 8'd0;
            end
            default: begin
                state_nxt  = WAIT_START;
                wr_ptr_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        drop_q <= drop;
        if (rst) begin
            state       <= WAIT_START;
            wr_ptr      <= 8'd0;
            bank_sel    <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            if (set_ovr) begin
                overrun <= 1'b1;
            end
            if (do_swap) begin
                bank_sel    <= ~bank_sel;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // bank_sel names the read bank; the other one is being filled.
    frame_bank #(.DEPTH(DATA_LENGTH), .IW(IW)) u_bank0 (
        .clk   (clk),
        .we    (we && !rst && bank_sel),
        .waddr (IW'(wr_idx)),
        .wdata (sample),
        .raddr (IW'(addr)),
        .rdata (rd0)
    );

    frame_bank #(.DEPTH(DATA_LENGTH), .IW(IW)) u_bank1 (
        .clk   (clk),
        .we    (we && !rst && !bank_sel),
        .waddr (IW'(wr_idx)),
        .wdata (sample),
        .raddr (IW'(addr)),
        .rdata (rd1)
    );

    assign in_range = 32'(addr) < DATA_LENGTH;

    always_comb begin
        data = OOR_DATA;
        if (frame_ready && in_range) begin
            data = bank_sel ? rd1 : rd0;
        end
    end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer: directed scenarios then random.
// Reference model collects frames in a queue and publishes whole arrays.
module tb_sample_frame_buffer;

    localparam int DL = 115;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample;
    logic       sample_valid;
    logic       frame_start;
    logic       drop;
    logic [7:0] addr;
    logic [7:0] data;
    logic       frame_ready;
    logic       overrun;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    sample_frame_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .frame_start  (frame_start),
        .drop         (drop),
        .addr         (addr),
        .data         (data),
        .frame_ready  (frame_ready),
        .overrun      (overrun),
        .frame_count  (frame_count)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       ovr;
    } sb_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] pub [256];
    logic [7:0] part [$];
    sb_t        sbq [$];
    bit         m_ready = 0;
    bit         m_over = 0;
    int         m_count = 0;
    bit         collecting = 0;
    bit         swap_pend = 0;
    bit         m_in_rst = 1;
    logic       m_drop = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_data(input logic [7:0] a);
        if (m_ready && int'(a) < DL) return int'(pub[a]);
        return 0;
    endfunction

    // Applies the rules to the inputs present at the clock edge.
    task automatic model_step();
        bit dreq;
        m_in_rst = rst;
        if (rst) begin
            m_ready = 0;
            m_over = 0;
            m_count = 0;
            collecting = 0;
            swap_pend = 0;
            part.delete();
            m_drop = drop;
            return;
        end
        dreq = (drop != m_drop);
        m_drop = drop;
        if (swap_pend) begin
            for (int i = 0; i < DL; i++) pub[i] = part[i];
            m_count = (m_count + 1) % 256;
            m_ready = 1;
            swap_pend = 0;
            part.delete();
            sbq.push_back('{cnt: 8'(m_count), ovr: m_over});
        end else if (dreq) begin
            collecting = 0;
            part.delete();
        end else if (frame_start) begin
            if (collecting) m_over = 1;
            collecting = 1;
            part.delete();
            if (sample_valid) part.push_back(sample);
        end else if (collecting && sample_valid) begin
            part.push_back(sample);
        end
        if (collecting && part.size() == DL) begin
            collecting = 0;
            swap_pend = 1;
        end
    endtask

    task automatic cyc(input bit r, input bit fs, input bit sv,
                       input logic [7:0] s, input bit tog,
                       input logic [7:0] a);
        rst = r;
        frame_start = fs;
        sample_valid = sv;
        sample = s;
        if (tog) drop = ~drop;
        addr = a;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [7:0] raddr();
        logic [7:0] edges [6];
        edges = '{8'd0, 8'd113, 8'd114, 8'd115, 8'd116, 8'd255};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic idle(input logic [7:0] a);
        cyc(0, 0, 0, 8'h00, 0, a);
    endtask

    task automatic feed(input int n, input bit start,
                        input logic [7:0] base, input bit ramp);
        for (int i = 0; i < n; i++) begin
            cyc(0, start && i == 0, 1,
                ramp ? base + 8'(i) : base, 0, raddr());
        end
    endtask

    task automatic peek(input string name, input logic [7:0] a,
                        input int exp);
        idle(a);
        check(name, int'(data), exp);
    endtask

    // Monitor: compares every cycle and pops on each publish.
    logic [7:0] last_cnt = 8'h00;
    always @(negedge clk) begin
        sb_t e;
        if (m_in_rst) begin
            last_cnt = 8'h00;
        end else begin
            check("frame_ready", int'(frame_ready), int'(m_ready));
            check("overrun", int'(overrun), int'(m_over));
            check("frame_count", int'(frame_count), m_count);
            check("data", int'(data), exp_data(addr));
            if (frame_count != last_cnt) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_publish: got count 0x%0h, none expected",
                             frame_count);
                end else begin
                    e = sbq.pop_front();
                    check("pub_count", int'(frame_count), int'(e.cnt));
                    check("pub_overrun", int'(overrun), int'(e.ovr));
                end
                last_cnt = frame_count;
            end
        end
    end

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        sample_valid = 1'b0;
        sample = 8'h00;
        drop = 1'b0;
        addr = 8'h00;
        cyc(1, 0, 0, 8'h00, 0, 8'h00);
        cyc(1, 0, 0, 8'h00, 0, 8'h00);
        idle(8'h05);
        check("reset_ready", int'(frame_ready), 0);
        check("reset_count", int'(frame_count), 0);
        check("reset_data", int'(data), 0);

        // Ramp frame 0x00..0x72
        feed(DL, 1, 8'h00, 1);
        idle(8'h00);
        check("ramp_ready", int'(frame_ready), 1);
        check("ramp_count", int'(frame_count), 1);
        peek("ramp_0x10", 8'h10, 8'h10);
        peek("ramp_0x72", 8'h72, 8'h72);
        peek("ramp_0x73", 8'h73, 8'h00);

        // Filling B must not disturb published A
        feed(DL, 1, 8'hAA, 0);
        idle(8'h00);
        feed(60, 1, 8'hBB, 0);
        peek("hold_a_0", 8'd0, 8'hAA);
        peek("hold_a_59", 8'd59, 8'hAA);
        peek("hold_a_114", 8'd114, 8'hAA);
        feed(DL - 60, 0, 8'hBB, 0);
        idle(8'h00);
        peek("pub_b_0", 8'd0, 8'hBB);
        peek("pub_b_114", 8'd114, 8'hBB);
        check("pub_b_count", int'(frame_count), 3);

        // Restart mid-frame
        feed(50, 1, 8'h22, 0);
        feed(DL, 1, 8'h11, 0);
        idle(8'h00);
        check("restart_overrun", int'(overrun), 1);
        check("restart_count", int'(frame_count), 4);
        peek("restart_0", 8'd0, 8'h11);
        peek("restart_114", 8'd114, 8'h11);

        // Drop discards the partial frame
        feed(30, 1, 8'h33, 0);
        cyc(0, 0, 0, 8'h00, 1, 8'h00);
        feed(85, 0, 8'h33, 0);
        idle(8'h00);
        idle(8'h00);
        check("drop_count", int'(frame_count), 4);
        peek("drop_old_50", 8'd50, 8'h11);

        // Start and first byte together
        cyc(0, 1, 1, 8'h5A, 0, 8'h00);
        feed(DL - 1, 0, 8'h01, 1);
        idle(8'h00);
        peek("first_byte", 8'd0, 8'h5A);
        check("first_count", int'(frame_count), 5);

        // Reset mid-fill
        feed(100, 1, 8'h44, 0);
        cyc(1, 0, 0, 8'h00, 0, 8'h00);
        idle(8'h00);
        check("rst_ready", int'(frame_ready), 0);
        check("rst_count", int'(frame_count), 0);
        peek("rst_data_0", 8'd0, 8'h00);
        peek("rst_data_114", 8'd114, 8'h00);
        feed(DL, 1, 8'h77, 0);
        idle(8'h00);
        check("after_rst_count", int'(frame_count), 1);
        peek("after_rst_7", 8'd7, 8'h77);

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            bit r, fs, sv, tog;
            r   = ($urandom_range(0, 2499) == 0);
            fs  = collecting ? ($urandom_range(0, 599) == 0)
                             : ($urandom_range(0, 19) == 0);
            sv  = ($urandom_range(0, 9) < 8);
            tog = ($urandom_range(0, 499) == 0);
            cyc(r, fs, sv, 8'($urandom), tog, raddr());
        end
        idle(8'h00);
        idle(8'h00);
        check("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
